// File: rtl/output_uart_streamer.sv
// Streams a run of output-register slots as 8N1 UART frames on tx.
// Each frame is a one-cycle LOAD (register read) followed by 10*CLKS_PER_BIT line cycles.
module output_uart_streamer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] first_index,
  input  logic [5:0] count,
  input  logic [7:0] output_value,
  output logic [4:0] output_index,
  output logic       read_enable,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FINISH} state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [5:0]      rem_q, rem_d;
  logic [7:0]      sh_q, sh_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            baud_last;

  assign baud_last = (baud_q == BAUD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_index;
          // 6-bit count can exceed the 32-slot register; clamp to a full sweep
          rem_d   = (count > 6'd32) ? 6'd32 : count;
          baud_d  = '0;
          state_d = (count == 6'd0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        sh_d    = output_value;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          rem_d   = rem_q - 6'd1;
          idx_d   = idx_q + 5'd1;
          state_d = (rem_q == 6'd1) ? FINISH : LOAD;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset forces them at once
  always_comb begin
    tx          = 1'b1;
    read_enable = (state_q == LOAD);
    busy        = (state_q != IDLE);
    done        = (state_q == FINISH);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign output_index = idx_q;

endmodule

// File: tb/tb_output_uart_streamer.sv
// Bench for output_uart_streamer: table runs, corner sequences and random runs
// checked cycle-by-cycle against a frame-level model of the UART stream.
module tb_output_uart_streamer;
  localparam int C  = 4;
  localparam int FR = 1 + 10*C;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] first_index;
  logic [5:0] count;
  logic [7:0] output_value;
  logic [4:0] output_index;
  logic       read_enable, tx, busy, done;

  logic [7:0] mem [32];
  int total = 0;
  int bad   = 0;

  assign output_value = mem[output_index];

  always #5 clk = ~clk;

  output_uart_streamer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(rst), .start(start), .first_index(first_index), .count(count),
    .output_value(output_value), .output_index(output_index), .read_enable(read_enable),
    .tx(tx), .busy(busy), .done(done)
  );

  typedef struct {
    string      nm;
    logic [4:0] f;
    logic [5:0] c;
    bit         special;
    bit         poke;
    int         busy_len;
    int         end_idx;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input bit special);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    if (special) begin
      mem[3]  = 8'hA5;
      mem[30] = 8'h11;
      mem[31] = 8'h22;
      mem[0]  = 8'h33;
    end
  endtask

  // Run one transfer, record every cycle at the falling edge, then compare to
  // the stream implied by the frame rules (LOAD, start bit, 8 LSB-first bits, stop).
  task automatic do_run(input string nm, input logic [4:0] f, input logic [5:0] c,
                        input bit poke, input int exp_busy, input int exp_idx);
    int n, L, k, o, bi;
    int e_tx, e_re, e_dn, e_bz;
    int n_tx, n_re, n_dn, n_bz, n_ix, blen, frames;
    logic [7:0] bytes [$];
    logic       s_tx [0:1399];
    logic       s_re [0:1399];
    logic       s_dn [0:1399];
    logic       s_bz [0:1399];
    logic [4:0] s_ix [0:1399];
    n = (int'(c) > 32) ? 32 : int'(c);
    L = n*FR + 1;
    for (int j = 0; j < n; j++) bytes.push_back(mem[(int'(f) + j) % 32]);

    @(posedge clk); #1;
    start = 1'b1; first_index = f; count = c;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= L + 2; i++) begin
      @(negedge clk);
      s_tx[i] = tx; s_re[i] = read_enable; s_dn[i] = done; s_bz[i] = busy; s_ix[i] = output_index;
      if (poke && i == 10)  begin start = 1'b1; first_index = f + 5'd5; count = 6'd7; end
      if (poke && i == 11)  start = 1'b0;
      if (i == L)           begin start = 1'b1; first_index = f + 5'd9; count = 6'd3; end
      if (i == L + 1)       start = 1'b0;
    end

    n_tx = 0; n_re = 0; n_dn = 0; n_bz = 0; n_ix = 0; blen = 0; frames = 0;
    for (int i = 1; i <= L + 2; i++) begin
      e_tx = 1; e_re = 0; e_dn = 0; e_bz = (i <= L) ? 1 : 0;
      if (i == L) e_dn = 1;
      else if (i < L) begin
        k = (i - 1) / FR;
        o = (i - 1) % FR;
        if (o == 0) begin
          e_re = 1;
          if (int'(s_ix[i]) != (int'(f) + k) % 32) n_ix++;
        end else if (o <= C) e_tx = 0;
        else if (o <= 9*C) begin
          bi   = (o - C - 1) / C;
          e_tx = int'(bytes[k][bi]);
        end
      end
      if (int'(s_tx[i]) != e_tx) begin
        if (n_tx == 0) $display("  %s: tx cycle %0d is %0b, model %0d", nm, i, s_tx[i], e_tx);
        n_tx++;
      end
      if (int'(s_re[i]) != e_re) n_re++;
      if (int'(s_dn[i]) != e_dn) n_dn++;
      if (int'(s_bz[i]) != e_bz) n_bz++;
      blen   += int'(s_bz[i]);
      frames += int'(s_re[i]);
    end
    chk({nm, " tx_stream_errs"}, n_tx, 0);
    chk({nm, " read_enable_errs"}, n_re, 0);
    chk({nm, " load_index_errs"}, n_ix, 0);
    chk({nm, " done_errs"}, n_dn, 0);
    chk({nm, " busy_errs"}, n_bz, 0);
    chk({nm, " busy_len"}, blen, exp_busy);
    chk({nm, " frames"}, frames, n);
    chk({nm, " end_index"}, int'(output_index), exp_idx);
  endtask

  vec_t tbl [6];

  initial begin
    int dcnt, bcnt, n, f, c;
    rst = 1'b1; start = 1'b0; first_index = '0; count = '0;
    fill(1'b0);
    #7;
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset read_enable", int'(read_enable), 0);
    chk("reset output_index", int'(output_index), 0);
    @(negedge clk); rst = 1'b0;

    tbl[0] = '{"single",      5'd3,  6'd1,  1'b1, 1'b0, 42,   4};
    tbl[1] = '{"wrap3",       5'd30, 6'd3,  1'b1, 1'b0, 124,  1};
    tbl[2] = '{"zero",        5'd7,  6'd0,  1'b1, 1'b0, 1,    7};
    tbl[3] = '{"busy_start",  5'd5,  6'd2,  1'b0, 1'b1, 83,   7};
    tbl[4] = '{"sweep_clamp", 5'd0,  6'd40, 1'b0, 1'b0, 1313, 0};
    tbl[5] = '{"clamp33",     5'd31, 6'd33, 1'b0, 1'b1, 1313, 31};
    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].special);
      do_run(tbl[t].nm, tbl[t].f, tbl[t].c, tbl[t].poke, tbl[t].busy_len, tbl[t].end_idx);
    end

    // Async reset during data bit 4 of a single-byte run
    fill(1'b1);
    @(posedge clk); #1;
    start = 1'b1; first_index = 5'd3; count = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 1 + C + 4*C + 1; i++) @(negedge clk);
    chk("pre_reset busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midreset tx", int'(tx), 1);
    chk("midreset busy", int'(busy), 0);
    chk("midreset read_enable", int'(read_enable), 0);
    chk("midreset output_index", int'(output_index), 0);
    chk("midreset done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      dcnt += int'(done);
      bcnt += int'(busy);
    end
    chk("post_reset done_count", dcnt, 0);
    chk("post_reset busy_count", bcnt, 0);
    do_run("after_reset", 5'd3, 6'd1, 1'b0, 42, 4);

    // Random runs against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      f = int'($urandom_range(0, 31));
      c = (r == 0) ? 0 : int'($urandom_range(0, 40));
      n = (c > 32) ? 32 : c;
      do_run($sformatf("rand%0d", r), 5'(f), 6'(c), bit'($urandom_range(0, 1)),
             n*FR + 1, (f + n) % 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
